// File: rtl/i2c_arb_pkg.sv
// Shared types and the round-robin pick function used by the I2C command arbiter
// and other shared-resource blocks.
package i2c_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    // One-hot winner: the first set request at or after (last+1) mod numReq.
    // Walking downward lets the closest candidate overwrite farther ones.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input int                    last,
        input int                    numReq
    );
        logic [RR_MAX_REQ-1:0] winner;
        logic [RR_IDX_W-1:0]   idx;
        winner = '0;
        for (int i = RR_MAX_REQ; i >= 1; i--) begin
            if (i <= numReq) begin
                idx = RR_IDX_W'((last + i) % numReq);
                if (req[idx]) begin
                    winner      = '0;
                    winner[idx] = 1'b1;
                end
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/axis_i2c_arbiter_rr.sv
// Combinational round-robin picker: request vector and previous winner in,
// one-hot grant and its binary index out.
module rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    assign o_grant = NUM_REQ'(rr_pick(RR_MAX_REQ'(i_req), int'(i_last), NUM_REQ));

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) begin
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream I2C command port between NUM_REQ
// requesters, with per-transaction grant locking, response routing and a stall watchdog.
module axis_i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int RSP_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
    input  logic [NUM_REQ-1:0]            req_tvalid_i,
    input  logic [NUM_REQ-1:0]            req_tlast_i,
    output logic [NUM_REQ-1:0]            req_tready_o,
    output logic [DATA_WIDTH-1:0]         i2c_tdata_o,
    output logic                          i2c_tvalid_o,
    output logic                          i2c_tlast_o,
    input  logic                          i2c_tready_i,
    input  logic [RSP_WIDTH-1:0]          i2c_rsp_tdata_i,
    input  logic                          i2c_rsp_tvalid_i,
    output logic                          i2c_rsp_tready_o,
    output logic [RSP_WIDTH-1:0]          rsp_tdata_o,
    output logic [NUM_REQ-1:0]            rsp_tvalid_o,
    input  logic [NUM_REQ-1:0]            rsp_tready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          timeout_o
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e             r_state;
    arb_state_e             w_nextState;
    logic [NUM_REQ-1:0]     r_grant;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_last;
    logic [CNT_W-1:0]       r_stallCnt;
    logic [NUM_REQ-1:0]     w_pickGrant;
    logic [IDX_W-1:0]       w_pickIdx;
    logic [DATA_WIDTH-1:0]  w_reqData [NUM_REQ];
    logic                   w_ownValid;
    logic                   w_ownLast;
    logic                   w_handshake;
    logic                   w_load;
    logic                   w_release;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_reqData[k] = req_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rrArbiter (
        .i_req   (req_tvalid_i),
        .i_last  (r_last),
        .o_grant (w_pickGrant),
        .o_idx   (w_pickIdx)
    );

    assign w_ownValid  = req_tvalid_i[r_owner];
    assign w_ownLast   = req_tlast_i[r_owner];
    assign w_handshake = (r_state == ARB_BURST) && w_ownValid && i2c_tready_i;

    always_comb begin
        w_nextState  = r_state;
        w_load       = 1'b0;
        w_release    = 1'b0;
        timeout_o    = 1'b0;
        req_tready_o = '0;
        i2c_tvalid_o = 1'b0;
        i2c_tlast_o  = 1'b0;
        i2c_tdata_o  = w_reqData[r_owner];
        case (r_state)
            ARB_IDLE: begin
                if (|req_tvalid_i) begin
                    w_load      = 1'b1;
                    w_nextState = ARB_BURST;
                end
            end
            ARB_BURST: begin
                i2c_tvalid_o          = w_ownValid;
                i2c_tlast_o           = w_ownLast;
                req_tready_o[r_owner] = i2c_tready_i;
                if (w_handshake && w_ownLast) begin
                    w_release   = 1'b1;
                    w_nextState = ARB_IDLE;
                end else if (!w_ownValid && (r_stallCnt == CNT_TERM)) begin
                    // Abort without a synthesized tlast; the master sees a truncated stream.
                    timeout_o   = 1'b1;
                    w_release   = 1'b1;
                    w_nextState = ARB_IDLE;
                end
            end
            default: w_nextState = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Owner survives the end of a burst so late responses still find their requester.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
        end else if (w_load) begin
            r_grant <= w_pickGrant;
            r_owner <= w_pickIdx;
            r_last  <= w_pickIdx;
        end else if (w_release) begin
            r_grant <= '0;
        end
    end

    // Only owner-valid-low cycles count; master backpressure holds the count.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_stallCnt <= '0;
        end else if ((r_state == ARB_IDLE) || w_handshake) begin
            r_stallCnt <= '0;
        end else if (!w_ownValid && (r_stallCnt != CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    always_comb begin
        rsp_tvalid_o          = '0;
        rsp_tvalid_o[r_owner] = i2c_rsp_tvalid_i;
    end

    assign i2c_rsp_tready_o = rsp_tready_i[r_owner];
    assign rsp_tdata_o      = i2c_rsp_tdata_i;
    assign grant_o          = r_grant;

endmodule
